adder_writeback: RTL and testbench

//  Downstream stage of the pipelined adder unit. Tags each op issued to the adder and tracks it through a valid/rd/tag

---
 rtl/adder_writeback.sv | 94 +++++++++
 tb/tb_adder_writeback.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adder_writeback.sv
// adder_writeback: latency-matched tag pipe around a stall-free adder, result FIFO and credit-gated issue.
module adder_writeback #(
  parameter int ADDER_DEPTH = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [4:0]                   issue_rd_i,
  input  logic [TAG_W-1:0]             issue_tag_i,
  input  logic [31:0]                  adder_result_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic                         wb_we_o,
  output logic [4:0]                   wb_rd_o,
  output logic [31:0]                  wb_data_o,
  output logic [TAG_W-1:0]             wb_tag_o,
  output logic [$clog2(FIFO_DEPTH):0]  occupancy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);
  logic [ADDER_DEPTH-1:0] v_q, v_d;
  logic [4:0]             rd_q [ADDER_DEPTH];
  logic [4:0]             rd_d [ADDER_DEPTH];
  logic [TAG_W-1:0]       tag_q [ADDER_DEPTH];
  logic [TAG_W-1:0]       tag_d [ADDER_DEPTH];
  logic [4:0]             mem_rd_q [FIFO_DEPTH];
  logic [TAG_W-1:0]       mem_tag_q [FIFO_DEPTH];
  logic [31:0]            mem_data_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]          cnt_q, cnt_d, inflight, occ;
  logic                   accept, cap, pop;
  always_comb begin
    inflight = '0;
    for (int k = 0; k < ADDER_DEPTH; k++) inflight = inflight + OW'(v_q[k]);
  end
  // Credit uses registered state only, so a pop frees a slot one cycle later.
  assign occ           = inflight + cnt_q;
  assign issue_ready_o = occ < FULL;
  assign occupancy_o   = occ;
  assign accept        = issue_valid_i & issue_ready_o & ~flush_i;
  assign cap           = reset_n_i & v_q[ADDER_DEPTH-1] & ~flush_i;
  assign wb_valid_o    = cnt_q != '0;
  assign pop           = wb_valid_o & wb_ready_i & ~flush_i;
  assign wb_rd_o       = wb_valid_o ? mem_rd_q[rd_ptr_q] : '0;
  assign wb_tag_o      = wb_valid_o ? mem_tag_q[rd_ptr_q] : '0;
  assign wb_data_o     = wb_valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign wb_we_o       = wb_valid_o & (wb_rd_o != 5'd0);
  always_comb begin
    v_d      = '0;
    rd_d     = rd_q;
    tag_d    = tag_q;
    v_d[0]   = accept;
    rd_d[0]  = issue_rd_i;
    tag_d[0] = issue_tag_i;
    for (int k = 1; k < ADDER_DEPTH; k++) begin
      v_d[k]   = v_q[k-1] & ~flush_i;
      rd_d[k]  = rd_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end
  assign wr_ptr_d = cap ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = flush_i ? wr_ptr_q : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign cnt_d    = flush_i ? '0 : (cap & ~pop) ? cnt_q + OW'(1) : (pop & ~cap) ? cnt_q - OW'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q      <= '0;
      rd_q     <= '{default: '0};
      tag_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      v_q      <= v_d;
      rd_q     <= rd_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (cap) begin
      mem_rd_q[wr_ptr_q]   <= rd_q[ADDER_DEPTH-1];
      mem_tag_q[wr_ptr_q]  <= tag_q[ADDER_DEPTH-1];
      mem_data_q[wr_ptr_q] <= adder_result_i;
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(cap && cnt_q == FULL));
endmodule

// File: tb/tb_adder_writeback.sv
// tb_adder_writeback: directed checks of latency, credits, ordering, flush and rd=0 handling.
module tb_adder_writeback;
  logic        clk = 1'b0;
  logic        reset_n, flush, iv, wbr;
  logic        issue_ready, wb_valid, wb_we;
  logic [4:0]  ird, wb_rd;
  logic [3:0]  itag, wb_tag;
  logic [31:0] a, b, adder_result, wb_data;
  logic [3:0]  occupancy;
  logic [31:0] ap [3];
  int          errors = 0;
  int          checks = 0;
  int          acc;
  adder_writeback #(.ADDER_DEPTH(3), .FIFO_DEPTH(8), .TAG_W(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_o(issue_ready), .issue_rd_i(ird), .issue_tag_i(itag),
    .adder_result_i(adder_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wbr), .wb_we_o(wb_we), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_tag_o(wb_tag), .occupancy_o(occupancy)
  );
  always #5 clk = ~clk;
  // Three-stage adder: operands sampled at an edge appear three cycles later.
  always @(posedge clk) begin
    ap[0] <= a + b;
    ap[1] <= ap[0];
    ap[2] <= ap[1];
  end
  assign adder_result = ap[2];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] x, input logic [31:0] y);
    iv = v; ird = rd; itag = tg; a = x; b = y;
  endtask
  initial begin
    reset_n = 1'b0; flush = 1'b0; wbr = 1'b1;
    drive(1'b1, 5'd3, 4'd1, 32'd1, 32'd1);
    // reset held two edges while issuing
    tick();
    tick();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_occ", {28'd0, occupancy}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_tag", {28'd0, wb_tag}, 32'd0);
    // latency: issue in cycle 0, writeback visible in cycle 4
    drive(1'b1, 5'd5, 4'd3, 32'd7, 32'd9);
    tick();
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    chk("lat_occ1", {28'd0, occupancy}, 32'd1);
    tick();
    tick();
    chk("lat_c3_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, wb_valid}, 32'd1);
    chk("lat_data", wb_data, 32'd16);
    chk("lat_rd", {27'd0, wb_rd}, 32'd5);
    chk("lat_tag", {28'd0, wb_tag}, 32'd3);
    chk("lat_we", {31'd0, wb_we}, 32'd1);
    tick();
    chk("lat_popped", {31'd0, wb_valid}, 32'd0);
    chk("lat_occ0", {28'd0, occupancy}, 32'd0);
    // backpressure: no pops, issue every cycle
    wbr = 1'b0;
    acc = 0;
    for (int n = 0; n < 14; n++) begin
      drive(1'b1, 5'(n + 1), 4'(n), 32'(10 * n), 32'd1);
      if (issue_ready) acc++;
      tick();
    end
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_ready0", {31'd0, issue_ready}, 32'd0);
    chk("bp_occ8", {28'd0, occupancy}, 32'd8);
    chk("bp_head_data", wb_data, 32'd1);
    wbr = 1'b1;
    tick();
    chk("bp_ready_after_pop", {31'd0, issue_ready}, 32'd1);
    chk("bp_occ7", {28'd0, occupancy}, 32'd7);
    for (int i = 1; i < 8; i++) begin
      chk("bp_drain_valid", {31'd0, wb_valid}, 32'd1);
      chk("bp_drain_data", wb_data, 32'(10 * i + 1));
      chk("bp_drain_tag", {28'd0, wb_tag}, 32'(i));
      chk("bp_drain_rd", {27'd0, wb_rd}, 32'(i + 1));
      tick();
    end
    chk("bp_empty", {31'd0, wb_valid}, 32'd0);
    chk("bp_occ0", {28'd0, occupancy}, 32'd0);
    // throughput: 20 back-to-back issues with the register file always ready
    for (int c = 0; c < 25; c++) begin
      if (c < 20) chk("tp_ready", {31'd0, issue_ready}, 32'd1);
      if (c < 4 || c > 23) chk("tp_idle", {31'd0, wb_valid}, 32'd0);
      else begin
        chk("tp_valid", {31'd0, wb_valid}, 32'd1);
        chk("tp_data", wb_data, 32'(100 + 2 * (c - 4)));
        chk("tp_tag", {28'd0, wb_tag}, 32'((c - 4) % 16));
        chk("tp_rd", {27'd0, wb_rd}, 32'((c - 4) % 31 + 1));
      end
      if (c >= 4 && c <= 20) chk("tp_occ_steady", {28'd0, occupancy}, 32'd4);
      if (c < 20) drive(1'b1, 5'(c % 31 + 1), 4'(c), 32'(100 + c), 32'(c));
      else drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
      tick();
    end
    // flush with one op queued and two in flight, plus an issue in the flush cycle
    wbr = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 5'(n + 1), 4'(n + 1), 32'd50, 32'(n));
      tick();
    end
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("fl_pre_valid", {31'd0, wb_valid}, 32'd1);
    chk("fl_pre_occ", {28'd0, occupancy}, 32'd3);
    flush = 1'b1;
    drive(1'b1, 5'd7, 4'd7, 32'd1, 32'd1);
    tick();
    flush = 1'b0;
    chk("fl_valid0", {31'd0, wb_valid}, 32'd0);
    chk("fl_occ0", {28'd0, occupancy}, 32'd0);
    chk("fl_ready", {31'd0, issue_ready}, 32'd1);
    wbr = 1'b1;
    drive(1'b1, 5'd9, 4'd10, 32'd1000, 32'd234);
    tick();
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    chk("fl_new_occ", {28'd0, occupancy}, 32'd1);
    for (int k = 6; k < 9; k++) begin
      chk("fl_no_stale", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    chk("fl_new_valid", {31'd0, wb_valid}, 32'd1);
    chk("fl_new_data", wb_data, 32'd1234);
    chk("fl_new_tag", {28'd0, wb_tag}, 32'd10);
    chk("fl_new_rd", {27'd0, wb_rd}, 32'd9);
    tick();
    chk("fl_new_popped", {31'd0, wb_valid}, 32'd0);
    // rd=0 still flows through the FIFO without a write enable
    drive(1'b1, 5'd0, 4'd5, 32'd3, 32'd4);
    tick();
    drive(1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    tick();
    chk("rd0_valid", {31'd0, wb_valid}, 32'd1);
    chk("rd0_we", {31'd0, wb_we}, 32'd0);
    chk("rd0_data", wb_data, 32'd7);
    chk("rd0_tag", {28'd0, wb_tag}, 32'd5);
    chk("rd0_rd", {27'd0, wb_rd}, 32'd0);
    tick();
    chk("rd0_popped", {31'd0, wb_valid}, 32'd0);
    chk("rd0_occ0", {28'd0, occupancy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
